// File: rtl/key_schedule_sequencer.sv
// ---------------------------------------------------------------------------
// key_schedule_sequencer
//   Iterative AES-128 key-schedule controller for the decrypt path. One
//   expand_single_round instance is stepped NR times, one round per clock.
//   All NR+1 round keys are held in a register file, which a random-access
//   read port serves so the decrypt core can walk them from NR down to 0.
//
//   Ports
//     clk, rst    rising-edge clock, synchronous active-high reset
//     key_valid   cipher key offered on key_in
//     key_ready   sequencer can accept a key (IDLE or READY)
//     key_in      128-bit cipher key, word0 in [127:96]
//     busy        expansion in progress
//     keys_valid  all NR+1 round keys stored and stable
//     rd_idx      round-key index to read, 0..NR
//     rd_key      rk[rd_idx], registered; 0 when not valid or out of range
//
//   Build option KEY_CACHE_EN: a key accepted in READY that equals rk[0]
//   leaves the stored schedule untouched, so keys_valid has no gap.
// ---------------------------------------------------------------------------

// One AES-128 key-expansion round. round_no outside 1..10 yields zero.
module expand_single_round (
    input  logic [3:0]   round_no,
    input  logic [127:0] before_ex,
    output logic [127:0] after_ex
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    always_comb begin
        case (round_no)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        {w0, w1, w2, w3} = before_ex;
        // RotWord then SubWord on w3, Rcon into the top byte.
        temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        after_ex = (rcon == 8'h00) ? '0 : {n0, n1, n2, n3};
    end
endmodule

module key_schedule_sequencer #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] rk_q [NR+1];
    logic [127:0] rk_d [NR+1];
    logic [127:0] rd_key_q, rd_key_d;
    logic [127:0] after_ex;
    logic         accept;
    logic         load;

    expand_single_round u_round (
        .round_no  (round_q),
        .before_ex (cur_q),
        .after_ex  (after_ex)
    );

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        cur_d      = cur_q;
        rk_d       = rk_q;
        key_ready  = (state_q != EXPAND);
        busy       = (state_q == EXPAND);
        keys_valid = (state_q == READY);
        accept     = key_valid & key_ready;
        load       = 1'b0;

        case (state_q)
            IDLE: load = accept;
            EXPAND: begin
                rk_d[round_q] = after_ex;
                cur_d         = after_ex;
                if (round_q == NR_L) state_d = READY;
                else                 round_d = round_q + 4'd1;
            end
            READY: begin
`ifdef KEY_CACHE_EN
                load = accept && (key_in != rk_q[0]);
`else
                load = accept;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            rk_d[0] = key_in;
            cur_d   = key_in;
            round_d = 4'd1;
            state_d = EXPAND;
        end

        if (keys_valid && (rd_idx <= NR_L)) rd_key_d = rk_q[rd_idx];
        else                                rd_key_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            round_q  <= '0;
            cur_q    <= '0;
            rk_q     <= '{default: '0};
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            cur_q    <= cur_d;
            rk_q     <= rk_d;
            rd_key_q <= rd_key_d;
        end
    end

    assign rd_key = rd_key_q;
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// ---------------------------------------------------------------------------
// tb_key_schedule_sequencer
//   Self-checking bench for key_schedule_sequencer (NR=10). The reference
//   schedule is the FIPS-197 word recurrence w[i] = w[i-4] ^ f(w[i-1]) with
//   an S-box built from log/antilog tables over generator 3.
// ---------------------------------------------------------------------------
module tb_key_schedule_sequencer;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_checks = 0;
    int n_fail   = 0;

    int           exp_t [256];
    int           log_t [256];
    logic [127:0] m_rk  [NR+1];

    key_schedule_sequencer #(.NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] v, s, c;
        c = 8'h63;
        v = (x == 8'h00) ? 8'h00 : 8'(exp_t[(255 - log_t[x]) % 255]);
        for (int i = 0; i < 8; i++)
            s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic build_tables();
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = int'(p);
            log_t[p] = i;
            p = p ^ xt(p);
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        {w[0], w[1], w[2], w[3]} = key;
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]) ^ rc, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offer key, wait for keys_valid within a bounded budget; optionally
    // hammer key_valid with a decoy key while expanding.
    task automatic expand_key(input string tag, input logic [127:0] key, input bit decoy);
        int lat;
        key_in    = key;
        key_valid = 1'b1;
        step();
        key_in    = decoy ? 128'h000102030405060708090a0b0c0d0e0f : '0;
        key_valid = decoy;
        check({tag, " busy"}, busy, 1);
        check({tag, " key_ready in expand"}, key_ready, 0);
        lat = 0;
        while (!keys_valid && lat < 30) begin
            step();
            lat++;
        end
        key_valid = 1'b0;
        check({tag, " latency"}, lat, NR);
        model_expand(key);
    endtask

    task automatic read_all(input string tag);
        for (int i = NR; i >= 0; i--) begin
            rd_idx = 4'(i);
            step();
            check($sformatf("%s rk[%0d]", tag, i), rd_key, m_rk[i]);
        end
        for (int i = NR + 1; i < 16; i++) begin
            rd_idx = 4'(i);
            step();
            check($sformatf("%s oob %0d", tag, i), rd_key, 0);
        end
    endtask

    initial begin
        int           idx;
        logic [127:0] k;
        bit           stayed;
        build_tables();
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_idx = '0;
        step(); step();
        rst = 1'b0;
        check("rst key_ready", key_ready, 1);
        check("rst busy", busy, 0);
        check("rst keys_valid", keys_valid, 0);
        check("rst rd_key", rd_key, 0);

        // FIPS-197 vector with decoy key offered during expansion.
        expand_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        rd_idx = 4'd1; step();
        check("fips rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; step();
        check("fips rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_all("fips");

        // Reset at round 5 of an expansion.
        key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (4) step();
        check("mid busy before rst", busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid rst busy", busy, 0);
        check("mid rst keys_valid", keys_valid, 0);
        check("mid rst key_ready", key_ready, 1);
        check("mid rst rd_key", rd_key, 0);
        rd_idx = 4'd0; step();
        check("mid rst no partial", rd_key, 0);
        expand_key("refips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        read_all("refips");

        // Back-to-back key from READY.
        check("b2b ready", key_ready, 1);
        expand_key("zero", '0, 1'b0);
        rd_idx = 4'd10; step();
        check("zero rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_all("zero");

        // Re-submit the current key.
        key_in = '0; key_valid = 1'b1;
`ifdef KEY_CACHE_EN
        step();
        key_valid = 1'b0;
        stayed = 1'b1;
        repeat (12) begin
            if (!keys_valid || busy) stayed = 1'b0;
            step();
        end
        check("cache no gap", stayed, 1);
        key_valid = 1'b0;
`else
        key_valid = 1'b0;
        expand_key("repeat", '0, 1'b0);
`endif
        read_all("repeat");

        // Random keys with random reads.
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand_key("rand", k, n[0]);
            for (int j = 0; j < 16; j++) begin
                idx = int'($urandom_range(0, 15));
                rd_idx = 4'(idx);
                step();
                check($sformatf("rand rd %0d", idx), rd_key, (idx > NR) ? '0 : m_rk[idx]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
